// File: rtl/ram_arbiter_2_pkg.sv
// Shared encodings and default widths for the two-requester RAM arbiter.
// Combinational constants only; no latency or flow control of its own.
package ram_arbiter_2_pkg;

    localparam int DEF_AW = 2;
    localparam int DEF_DW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage

// File: rtl/ram_arbiter_2_if.sv
// Requester handshakes and RAM port of the arbiter, bundled as one interface.
// Wires only; the arbiter (slave side) owns every registered output.
interface ram_arbiter_2_if
    import ram_arbiter_2_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;
    logic          busy;

    logic [DW-1:0] ram_data_in;
    logic [AW-1:0] ram_ad_in;
    logic          ram_en;
    logic          ram_rdwr;
    logic [DW-1:0] ram_data_out;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_data_out,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata, busy,
        output ram_data_in, ram_ad_in, ram_en, ram_rdwr
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_data_out,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata, busy,
        input  ram_data_in, ram_ad_in, ram_en, ram_rdwr
    );
endinterface

// File: rtl/ram_4x4.sv
// Small synchronous RAM: write on enabled write edge, registered read data.
// One-cycle read latency; data_out holds until the next enabled read.
module ram_4x4 #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic [DW-1:0] data_in,
    input  logic [AW-1:0] ad_in,
    input  logic          en,
    input  logic          rdwr,
    output logic [DW-1:0] data_out
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (rdwr) mem[ad_in] <= data_in;
            else      data_out   <= mem[ad_in];
        end
    end
endmodule

// File: rtl/ram_arbiter_2_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to
// whoever was not granted last. Zero latency; no backpressure.
module ram_arbiter_2_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    always_comb begin
        any = |req;
        if (req == 2'b11) winner = ~last;
        else              winner = req[1];
    end
endmodule

// File: rtl/ram_arbiter_2.sv
// Round-robin arbiter serialising two requesters onto one RAM port.
// Write: IDLE->ISSUE (2 cycles); read: IDLE->ISSUE->RESP (3 cycles); requests wait in IDLE.
module ram_arbiter_2
    import ram_arbiter_2_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic           CLK,
    input  logic           RST,
    ram_arbiter_2_if.slave bus
);
    state_t        state, state_nx;
    logic          win_q, we_q, last_q;
    logic [AW-1:0] ad_q;
    logic [DW-1:0] dat_q;
    logic          pick_win, pick_any;

    ram_arbiter_2_rr_pick2 u_rr_pick2 (
        .req    ({bus.req1, bus.req0}),
        .last   (last_q),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Winner's request is captured only at the IDLE sample; later changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win_q  <= 1'b0;
            we_q   <= RD;
            last_q <= 1'b1;
            ad_q   <= '0;
            dat_q  <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                win_q <= pick_win;
                we_q  <= pick_win ? bus.we1    : bus.we0;
                ad_q  <= pick_win ? bus.addr1  : bus.addr0;
                dat_q <= pick_win ? bus.wdata1 : bus.wdata0;
            end
            if (state == ISSUE) last_q <= win_q;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = ISSUE;
            ISSUE:   state_nx = (we_q == WR) ? IDLE : RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_en   = 1'b0;
        bus.ram_rdwr = RD;
        bus.gnt0     = 1'b0;
        bus.gnt1     = 1'b0;
        bus.rvalid0  = 1'b0;
        bus.rvalid1  = 1'b0;
        case (state)
            ISSUE: begin
                bus.ram_en   = 1'b1;
                bus.ram_rdwr = we_q;
                bus.gnt0     = ~win_q;
                bus.gnt1     = win_q;
            end
            RESP: begin
                bus.rvalid0 = ~win_q;
                bus.rvalid1 = win_q;
            end
            default: ;
        endcase
        bus.busy        = (state != IDLE);
        bus.rdata       = bus.ram_data_out;
        bus.ram_ad_in   = ad_q;
        bus.ram_data_in = dat_q;
    end
endmodule

// File: doc/ram_arbiter_2.md
Name: ram_arbiter_2

Overview:
Two-requester round-robin arbiter and sequencer for the shared ram_4x4 storage block. Each requester presents one read or write with a req/gnt handshake. The arbiter serialises accesses onto the single RAM port, driving data_in/ad_in/en/rdwr, and returns read data with a per-requester valid strobe. It sits between two client engines and the ram_4x4 instance.

Parameters:
AW, 2, address width (RAM depth 2**AW)
DW, 4, data width

Ports:
CLK  in  1  clock, all state updates on posedge
RST  in  1  asynchronous active-high reset
req0  in  1  requester 0 access request, held until gnt0
we0  in  1  requester 0: 1 = write, 0 = read
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  one-cycle accept pulse to requester 0
rvalid0  out  1  one-cycle read-data-valid for requester 0
req1/we1/addr1/wdata1/gnt1/rvalid1  same as above for requester 1
rdata  out  DW  read data, meaningful only while rvalid0 or rvalid1 is high
busy  out  1  high whenever state != IDLE
ram_data_in  out  DW  to RAM data_in
ram_ad_in  out  AW  to RAM ad_in
ram_en  out  1  to RAM en
ram_rdwr  out  1  to RAM rdwr (1 = write, 0 = read)
ram_data_out  in  DW  from RAM data_out

Behaviour:
- RAM contract: write at posedge when en=1 and rdwr=1. Read when en=1 and rdwr=0; ram_data_out valid from the following posedge until the next enabled read.
- Reset (RST=1, asynchronous): state=IDLE; gnt*, rvalid*, ram_en, ram_rdwr=0; ram_ad_in, ram_data_in=0; last_gnt=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Neither req high: stay.
  - Otherwise pick the winner: the only requester asserting; if both, the one != last_gnt.
  - Register winner id, we, addr, wdata into the RAM drive registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_en=1, ram_rdwr=we_latched, gnt[winner]=1.
  - last_gnt<=winner.
  - Next state: RESP if read, IDLE if write.
- RESP (exactly 1 cycle):
  - ram_en=0; rvalid[winner]=1; rdata=ram_data_out.
  - Next state: IDLE.
- All RAM drive outputs, gnt* and rvalid* are registered (state-decoded from registers). No combinational path from req* to any output.
- Latency: write = 2 cycles from req sampled to RAM write edge. Read = req sampled, +1 ISSUE, +1 RESP with rvalid; 3 cycles per read.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples gnt=1, then may drop or re-raise req for a new transfer.
  - Requests are sampled only in IDLE; changes during ISSUE/RESP are ignored.
- Fairness: with both req continuously high, grants alternate 0,1,0,1. Neither requester waits more than one other transaction.
- Same requester back-to-back: allowed; it wins immediately if the other is idle.
- Write-then-read same address: the read returns the new data (serialised, no bypass needed).
- Address/data widths are pass-through; no arithmetic. AW/DW must match the RAM instance.
- rdata holds the RAM output outside RESP; clients must qualify it with rvalid.
- Reset mid-operation: an in-flight read is dropped (no rvalid) and an ISSUE write is abandoned. RAM contents are not cleared by the arbiter.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), rdwr encoding constants (RD=0, WR=1), default AW/DW.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker (req[1:0], last -> winner, any). The FSM and registers live in ram_arbiter_2. The bench instantiates ram_4x4 alongside the arbiter.

Test Plan:
- Reset then req0 write addr=01 data=1001 -> ISSUE 1 cycle later with ram_en=1, ram_rdwr=1, ram_ad_in=01, gnt0 pulse; RAM[1]=1001.
- req1 read addr=01 after the above -> gnt1 in ISSUE, next cycle rvalid1=1 with rdata=1001; rvalid0 stays 0.
- req0 and req1 raised in the same cycle right after reset, both writes (0->addr10=1011, 1->addr11=0101) -> gnt0 first, then gnt1. Later reads return 1011 and 0101.
- Both requesters continuously requesting reads for 6 transactions -> grant order 0,1,0,1,0,1. Each read takes 3 cycles; busy is never low between transactions longer than the IDLE cycle.
- RST asserted asynchronously during RESP of a read -> all outputs 0 immediately, no rvalid, state IDLE. After release, req1 still beats nothing; req0 wins a tie first.
- Requester changes addr while waiting (before gnt), e.g. 00->11 -> access uses the value present at the IDLE sample cycle in which it won.
